// File: rtl/draw_text_banner.sv
// rtl/draw_text_banner.sv - text banner overlay stage for the VGA pixel pipeline
// Three-stage pass-through with font addressing, box/glyph colouring and a frame-locked blink FSM.
module draw_text_banner #(
  parameter int          X_POS        = 232,
  parameter int          Y_POS        = 208,
  parameter int          CHARS        = 7,
  parameter int          SCALE_LOG2   = 3,
  parameter int          BLINK_FRAMES = 30,
  parameter int          FILL_SCREEN  = 0,
  parameter logic [11:0] BOX_COLOR    = 12'hBDF,
  parameter logic [11:0] TXT_COLOR    = 12'hB1F
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        show_in,
  input  logic [7:0]  char_pixels,
  output logic [7:0]  char_x,
  output logic [3:0]  char_line,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        active_out
);

  localparam logic [10:0] X0       = 11'(X_POS);
  localparam logic [10:0] Y0       = 11'(Y_POS);
  localparam logic [15:0] X_LO     = 16'(X_POS);
  localparam logic [15:0] X_HI     = 16'(X_POS + CHARS * 8 * (2 ** SCALE_LOG2));
  localparam logic [15:0] Y_LO     = 16'(Y_POS);
  localparam logic [15:0] Y_HI     = 16'(Y_POS + 16 * (2 ** SCALE_LOG2));
  localparam int          CW       = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;
  localparam int          LAST     = (BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

  typedef struct packed {
    logic [10:0] hc;
    logic        hs;
    logic        hb;
    logic [10:0] vc;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
  } tmg_t;

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  tmg_t          s0, d1, d2, q;
  state_t        state;
  logic [CW-1:0] frame_cnt;
  logic          vsync_q;
  logic          vs_rise;
  logic [10:0]   dx0, dy0, dx2;
  logic [2:0]    col;
  logic          in_box, glyph;
  logic [11:0]   rgb_nxt;

  assign s0 = '{hc: hcount_in, hs: hsync_in, hb: hblnk_in, vc: vcount_in,
                vs: vsync_in, vb: vblnk_in, rgb: rgb_in};

  // Font address is issued at stage 0 so the two-cycle ROM chain lines up with stage 2.
  assign dx0       = hcount_in - X0;
  assign dy0       = vcount_in - Y0;
  assign char_x    = rst ? 8'd0 : 8'(dx0 >> (3 + SCALE_LOG2));
  assign char_line = rst ? 4'd0 : 4'(dy0 >> SCALE_LOG2);

  assign dx2    = d2.hc - X0;
  assign col    = 3'(dx2 >> SCALE_LOG2);
  assign glyph  = char_pixels[3'd7 - col];
  assign in_box = ({5'd0, d2.hc} >= X_LO) && ({5'd0, d2.hc} < X_HI) &&
                  ({5'd0, d2.vc} >= Y_LO) && ({5'd0, d2.vc} < Y_HI);
  assign vs_rise = vsync_in & ~vsync_q;

  always_comb begin
    rgb_nxt = d2.rgb;
    if (d2.hb | d2.vb)                          rgb_nxt = 12'h000;
    else if (state == IDLE)                     rgb_nxt = d2.rgb;
    else if (in_box && glyph && (state == ON))  rgb_nxt = TXT_COLOR;
    else if (in_box)                            rgb_nxt = BOX_COLOR;
    else if (FILL_SCREEN != 0)                  rgb_nxt = BOX_COLOR;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      d1 <= '0;
      d2 <= '0;
      q  <= '0;
    end else begin
      d1 <= s0;
      d2 <= d1;
      q  <= '{hc: d2.hc, hs: d2.hs, hb: d2.hb, vc: d2.vc,
              vs: d2.vs, vb: d2.vb, rgb: rgb_nxt};
    end
  end

  // Display mode only changes at the start of a frame, so a banner never tears mid-picture.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
      vsync_q   <= 1'b0;
    end else begin
      vsync_q <= vsync_in;
      if (vs_rise) begin
        if (!show_in) begin
          state     <= IDLE;
          frame_cnt <= '0;
        end else if (state == IDLE) begin
          state     <= ON;
          frame_cnt <= '0;
        end else if (BLINK_FRAMES != 0) begin
          if (frame_cnt == CNT_LAST) begin
            state     <= (state == ON) ? OFF : ON;
            frame_cnt <= '0;
          end else begin
            frame_cnt <= frame_cnt + CW'(1);
          end
        end
      end
    end
  end

  assign hcount_out = q.hc;
  assign hsync_out  = q.hs;
  assign hblnk_out  = q.hb;
  assign vcount_out = q.vc;
  assign vsync_out  = q.vs;
  assign vblnk_out  = q.vb;
  assign rgb_out    = q.rgb;
  assign active_out = (state != IDLE);

endmodule

// File: tb/tb_draw_text_banner.sv
// tb/tb_draw_text_banner.sv - randomized model-checked bench for draw_text_banner
// Two instances (default and fast-blink/fill/scale-1) share one stimulus stream.
module tb_draw_text_banner;

  localparam int          X   = 232;
  localparam int          Y   = 208;
  localparam int          CH  = 7;
  localparam logic [11:0] BOX = 12'hBDF;
  localparam logic [11:0] TXT = 12'hB1F;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hc, vc;
  logic        hs, hb, vs, vb, show;
  logic [11:0] rgb_in;
  logic [7:0]  cp;

  logic [7:0]  cx_o  [2];
  logic [3:0]  cl_o  [2];
  logic [10:0] hc_o  [2];
  logic [10:0] vc_o  [2];
  logic        hs_o  [2];
  logic        hb_o  [2];
  logic        vs_o  [2];
  logic        vb_o  [2];
  logic [11:0] rgb_o [2];
  logic        act_o [2];

  always #5 pclk = ~pclk;

  draw_text_banner dut_a (
    .pclk(pclk), .rst(rst), .hcount_in(hc), .hsync_in(hs), .hblnk_in(hb),
    .vcount_in(vc), .vsync_in(vs), .vblnk_in(vb), .rgb_in(rgb_in), .show_in(show),
    .char_pixels(cp), .char_x(cx_o[0]), .char_line(cl_o[0]), .hcount_out(hc_o[0]),
    .hsync_out(hs_o[0]), .hblnk_out(hb_o[0]), .vcount_out(vc_o[0]), .vsync_out(vs_o[0]),
    .vblnk_out(vb_o[0]), .rgb_out(rgb_o[0]), .active_out(act_o[0]));

  draw_text_banner #(.SCALE_LOG2(1), .BLINK_FRAMES(2), .FILL_SCREEN(1)) dut_b (
    .pclk(pclk), .rst(rst), .hcount_in(hc), .hsync_in(hs), .hblnk_in(hb),
    .vcount_in(vc), .vsync_in(vs), .vblnk_in(vb), .rgb_in(rgb_in), .show_in(show),
    .char_pixels(cp), .char_x(cx_o[1]), .char_line(cl_o[1]), .hcount_out(hc_o[1]),
    .hsync_out(hs_o[1]), .hblnk_out(hb_o[1]), .vcount_out(vc_o[1]), .vsync_out(vs_o[1]),
    .vblnk_out(vb_o[1]), .rgb_out(rgb_o[1]), .active_out(act_o[1]));

  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs, hb, vs, vb;
    logic [11:0] rgb;
  } px_t;

  px_t         hist[$];
  px_t         exp_t;
  logic [11:0] exp_rgb[2];
  int          mstate[2];   // 0 idle, 1 text shown, 2 text hidden
  int          mcnt[2];
  logic        m_vsq;
  logic [11:0] probe_rgb;
  int          total = 0;
  int          bad   = 0;

  function automatic int p_scale(int i); return (i == 0) ? 3 : 1; endfunction
  function automatic int p_blink(int i); return (i == 0) ? 30 : 2; endfunction
  function automatic int p_fill(int i);  return (i == 0) ? 0 : 1; endfunction

  function automatic logic [11:0] model_rgb(int i, px_t e, logic [7:0] c);
    int  s, w, h, col;
    bit  inb;
    s = p_scale(i);
    w = CH * 8 * (1 << s);
    h = 16 * (1 << s);
    if (e.hb || e.vb) return 12'h000;
    if (mstate[i] == 0) return e.rgb;
    inb = (int'(e.hc) >= X) && (int'(e.hc) < X + w) && (int'(e.vc) >= Y) && (int'(e.vc) < Y + h);
    if (inb) begin
      col = ((int'(e.hc) - X) / (1 << s)) % 8;
      if (c[7-col] && mstate[i] == 1) return TXT;
      return BOX;
    end
    return (p_fill(i) != 0) ? BOX : e.rgb;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_edge();
    px_t cur, z;
    bit  rise;
    cur = '{hc: hc, vc: vc, hs: hs, hb: hb, vs: vs, vb: vb, rgb: rgb_in};
    z   = '{hc: 0, vc: 0, hs: 0, hb: 0, vs: 0, vb: 0, rgb: 0};
    if (rst) begin
      hist  = {z, z};
      exp_t = z;
      m_vsq = 1'b0;
      for (int i = 0; i < 2; i++) begin
        exp_rgb[i] = 12'h000; mstate[i] = 0; mcnt[i] = 0;
      end
      return;
    end
    exp_t = hist[0];
    for (int i = 0; i < 2; i++) exp_rgb[i] = model_rgb(i, hist[0], cp);
    void'(hist.pop_front());
    hist.push_back(cur);
    rise  = vs && !m_vsq;
    m_vsq = vs;
    if (rise) begin
      for (int i = 0; i < 2; i++) begin
        if (!show) begin
          mstate[i] = 0; mcnt[i] = 0;
        end else if (mstate[i] == 0) begin
          mstate[i] = 1; mcnt[i] = 0;
        end else if (p_blink(i) != 0) begin
          if (mcnt[i] == p_blink(i) - 1) begin
            mstate[i] = 3 - mstate[i]; mcnt[i] = 0;
          end else begin
            mcnt[i]++;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [10:0] dx, dy;
    int          s;
    dx = hc - 11'(X);
    dy = vc - 11'(Y);
    for (int i = 0; i < 2; i++) begin
      s = p_scale(i);
      check($sformatf("rgb[%0d]", i), 32'(rgb_o[i]), 32'(exp_rgb[i]));
      check($sformatf("timing[%0d]", i),
            32'({hc_o[i], vc_o[i], hs_o[i], hb_o[i], vs_o[i], vb_o[i]}),
            32'({exp_t.hc, exp_t.vc, exp_t.hs, exp_t.hb, exp_t.vs, exp_t.vb}));
      check($sformatf("active[%0d]", i), 32'(act_o[i]), 32'(mstate[i] != 0));
      check($sformatf("addr[%0d]", i), 32'({cx_o[i], cl_o[i]}),
            rst ? 32'd0 : 32'({8'((int'(dx) / (1 << (3 + s))) % 256), 4'((int'(dy) / (1 << s)) % 16)}));
    end
  endtask

  task automatic step();
    @(posedge pclk);
    model_edge();
    @(negedge pclk);
    compare_all();
  endtask

  task automatic vs_pulse();
    vs = 1'b1; step();
    vs = 1'b0; step();
  endtask

  task automatic probe(input logic [10:0] x, input logic [10:0] y, input logic blank, input logic [7:0] c);
    hc = x; vc = y; hb = blank; cp = c;
    rgb_in = 12'($urandom); probe_rgb = rgb_in;
    step();
    rgb_in = 12'($urandom);
    step();
    step();
  endtask

  initial begin
    int rst_hold;
    rst = 1'b1; hc = '0; vc = '0; hs = 0; hb = 0; vs = 0; vb = 0; show = 0;
    rgb_in = '0; cp = '0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    show = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      vs_pulse();
      if (f == 1) begin
        check("lit_active_on", 32'(act_o[0]), 32'd1);
        probe(11'd232, 11'd208, 1'b0, 8'h00);
        check("lit_box_plain", 32'(rgb_o[0]), 32'h0BDF);
        check("lit_char_x0", 32'(cx_o[0]), 32'd0);
        check("lit_char_line0", 32'(cl_o[0]), 32'd0);
        for (int x = 232; x <= 239; x++) begin
          probe(11'(x), 11'd208, 1'b0, 8'h80);
          check("lit_glyph", 32'(rgb_o[0]), 32'h0B1F);
        end
        hc = 11'd296; #1;
        check("lit_char_x1", 32'(cx_o[0]), 32'd1);
        probe(11'd680, 11'd208, 1'b0, 8'hFF);
        check("lit_right_edge", 32'(rgb_o[0]), 32'(probe_rgb));
      end
      probe(11'd232, 11'd208, 1'b0, 8'hFF);
      check("lit_blink_b", 32'(rgb_o[1]), (f <= 2 || f >= 5) ? 32'h0B1F : 32'h0BDF);
      check("lit_steady_a", 32'(rgb_o[0]), 32'h0B1F);
    end

    probe(11'd240, 11'd210, 1'b1, 8'hFF);
    check("lit_hblank", 32'(rgb_o[0]), 32'd0);
    probe(11'd0, 11'd0, 1'b0, 8'hFF);
    check("lit_fill_b", 32'(rgb_o[1]), 32'h0BDF);
    check("lit_nofill_a", 32'(rgb_o[0]), 32'(probe_rgb));

    show = 1'b0;
    probe(11'd232, 11'd208, 1'b0, 8'h00);
    check("lit_hold_box", 32'(rgb_o[0]), 32'h0BDF);
    check("lit_hold_active", 32'(act_o[0]), 32'd1);
    vs_pulse();
    probe(11'd232, 11'd208, 1'b0, 8'h00);
    check("lit_hidden", 32'(rgb_o[0]), 32'(probe_rgb));
    check("lit_idle", 32'(act_o[0]), 32'd0);

    show = 1'b1;
    vs_pulse();
    probe(11'd300, 11'd220, 1'b0, 8'h00);
    rst = 1'b1; #1;
    check("lit_rst_rgb", 32'(rgb_o[0]), 32'd0);
    check("lit_rst_active", 32'(act_o[0]), 32'd0);
    check("lit_rst_hcount", 32'(hc_o[0]), 32'd0);
    step(); step();
    rst = 1'b0;
    probe(11'd232, 11'd208, 1'b0, 8'hFF);
    check("lit_rst_pass", 32'(rgb_o[0]), 32'(probe_rgb));
    check("lit_rst_idle", 32'(act_o[0]), 32'd0);
    vs_pulse();
    check("lit_redisplay", 32'(act_o[0]), 32'd1);

    rst_hold = 0;
    for (int n = 0; n < 15000; n++) begin
      if ($urandom_range(0, 7) == 0) hc = 11'($urandom);
      else                           hc = 11'($urandom_range(200, 720));
      vc     = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(190, 350));
      hs     = 1'($urandom);
      hb     = ($urandom_range(0, 15) == 0);
      vb     = ($urandom_range(0, 15) == 0);
      rgb_in = 12'($urandom);
      cp     = 8'($urandom);
      if ($urandom_range(0, 23) == 0) vs = ~vs;
      if ($urandom_range(0, 2999) == 0) show = ~show;
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 2999) == 0) rst_hold = 2;
      rst = (rst_hold > 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
